// File: rtl/pkg_bus.sv
// Shared system-bus types and helpers for the LLC bus controller and the
// schedulers that reuse its arbitration.
package pkg_bus;

   typedef enum logic [2:0] {
      OP_NOP        = 3'b000,
      OP_READ       = 3'b001,
      OP_WRITE      = 3'b010,
      OP_INVALIDATE = 3'b011,
      OP_RWIM       = 3'b100
   } bus_operation_e;

   typedef enum logic [1:0] {
      SNP_NOHIT = 2'b00,
      SNP_HIT   = 2'b01,
      SNP_HITM  = 2'b10,
      SNP_RSVD  = 2'b11
   } snoop_result_e;

   typedef struct packed {
      bus_operation_e operation;
      logic [31:0]    address;
      logic [3:0]     cache_id;
   } bus_msg_st;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_SNOOP = 3'd2,
      ST_DATA  = 3'd3,
      ST_RESP  = 3'd4
   } bus_ctrl_state_e;

   // HITM dominates HIT dominates NOHIT; the reserved code carries no hit.
   function automatic snoop_result_e merge_snoop(input snoop_result_e a, input snoop_result_e b);
      snoop_result_e res;
      if (a == SNP_HITM || b == SNP_HITM) begin
         res = SNP_HITM;
      end else if (a == SNP_HIT || b == SNP_HIT) begin
         res = SNP_HIT;
      end else begin
         res = SNP_NOHIT;
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping at N.
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W:0] pos_s;
   logic           found_s;

   // Scan from the pointer; the extra pos bit absorbs the wrap before reducing mod N.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found_s   = 1'b0;
      pos_s     = '0;
      for (int i = 0; i < N; i++) begin
         pos_s = {1'b0, ptr} + (IDX_W + 1)'(i);
         if (pos_s >= (IDX_W + 1)'(N)) begin
            pos_s = pos_s - (IDX_W + 1)'(N);
         end else begin
            pos_s = pos_s;
         end
         if (!found_s && req[pos_s[IDX_W-1:0]]) begin
            grant[pos_s[IDX_W-1:0]] = 1'b1;
            grant_idx               = pos_s[IDX_W-1:0];
            found_s                 = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/llc_bus_ctrl.sv
// LLC system-bus sequencer: round-robin grant, address phase, snoop collection
// and merge, data-beat counting, then a one-cycle response to the requester.
module llc_bus_ctrl
   import pkg_bus::*;
#(
   parameter int         NUM_REQ       = 2,
   parameter int         NUM_SNOOPERS  = 3,
   parameter int         DATA_BEATS    = 4,
   parameter int         SNOOP_TIMEOUT = 16,
   parameter logic [3:0] CACHE_ID      = 4'h0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*3-1:0]         req_op,
   input  logic [NUM_REQ*32-1:0]        req_addr,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output snoop_result_e                rsp_snoop,
   output logic                         rsp_timeout,
   output logic                         bus_valid,
   output bus_msg_st                    bus_msg,
   input  logic                         bus_ack,
   input  logic [NUM_SNOOPERS-1:0]      snoop_valid,
   input  logic [NUM_SNOOPERS*2-1:0]    snoop_result,
   input  logic                         beat_done,
   output logic                         busy
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam int TO_W = $clog2(SNOOP_TIMEOUT) + 1;
   localparam int BT_W = $clog2(DATA_BEATS) + 1;

   bus_operation_e          req_op_s   [NUM_REQ];
   logic [31:0]             req_addr_s [NUM_REQ];
   snoop_result_e           snp_res_s  [NUM_SNOOPERS];

   bus_ctrl_state_e         state_r, state_s;
   bus_operation_e          op_r, op_s;
   logic [31:0]             addr_r, addr_s;
   logic [ID_W-1:0]         id_r, id_s;
   logic [ID_W-1:0]         ptr_r, ptr_s;
   logic [NUM_SNOOPERS-1:0] mask_r, mask_s;
   logic [TO_W-1:0]         cnt_r, cnt_s;
   logic [BT_W-1:0]         beat_r, beat_s;
   snoop_result_e           acc_r, acc_s;
   logic                    tmo_r, tmo_s;
   logic                    snoop_done_s;
   logic [NUM_REQ-1:0]      grant_s;
   logic [ID_W-1:0]         gidx_s;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
      assign req_op_s[g]   = bus_operation_e'(req_op[g*3 +: 3]);
      assign req_addr_s[g] = req_addr[g*32 +: 32];
   end

   for (genvar g = 0; g < NUM_SNOOPERS; g++) begin : g_snp
      assign snp_res_s[g] = snoop_result_e'(snoop_result[g*2 +: 2]);
   end

   rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
      .req       (req_valid),
      .ptr       (ptr_r),
      .grant     (grant_s),
      .grant_idx (gidx_s)
   );

   // Next-state and transaction-context update; req_ready is a same-cycle handshake.
   always_comb begin
      state_s      = state_r;
      op_s         = op_r;
      addr_s       = addr_r;
      id_s         = id_r;
      ptr_s        = ptr_r;
      mask_s       = mask_r;
      cnt_s        = cnt_r;
      beat_s       = beat_r;
      acc_s        = acc_r;
      tmo_s        = tmo_r;
      req_ready    = '0;
      snoop_done_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (|req_valid) begin
               req_ready = grant_s;
               op_s      = req_op_s[gidx_s];
               addr_s    = req_addr_s[gidx_s];
               id_s      = gidx_s;
               if (gidx_s == ID_W'(NUM_REQ - 1)) begin
                  ptr_s = '0;
               end else begin
                  ptr_s = gidx_s + ID_W'(1);
               end
               mask_s  = '0;
               cnt_s   = '0;
               beat_s  = '0;
               acc_s   = SNP_NOHIT;
               tmo_s   = 1'b0;
               state_s = ST_ADDR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (bus_ack) begin
               state_s = ST_SNOOP;
            end else begin
               state_s = ST_ADDR;
            end
         end
         ST_SNOOP: begin
            // First strobe per snooper wins; later repeats are masked off.
            for (int i = 0; i < NUM_SNOOPERS; i++) begin
               if (snoop_valid[i] && !mask_r[i]) begin
                  mask_s[i] = 1'b1;
                  acc_s     = merge_snoop(acc_s, snp_res_s[i]);
               end else begin
                  mask_s[i] = mask_s[i];
               end
            end
            snoop_done_s = &mask_s;
            if (snoop_done_s || cnt_r == TO_W'(SNOOP_TIMEOUT - 1)) begin
               tmo_s   = ~snoop_done_s;
               state_s = (op_r == OP_INVALIDATE) ? ST_RESP : ST_DATA;
            end else begin
               cnt_s = cnt_r + TO_W'(1);
            end
         end
         ST_DATA: begin
            if (beat_done) begin
               if (beat_r == BT_W'(DATA_BEATS - 1)) begin
                  state_s = ST_RESP;
               end else begin
                  beat_s = beat_r + BT_W'(1);
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_RESP: begin
            state_s = ST_IDLE;
            op_s    = OP_NOP;
            addr_s  = '0;
            id_s    = '0;
            mask_s  = '0;
            cnt_s   = '0;
            beat_s  = '0;
            acc_s   = SNP_NOHIT;
            tmo_s   = 1'b0;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and transaction context registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         op_r    <= OP_NOP;
         addr_r  <= '0;
         id_r    <= '0;
         ptr_r   <= '0;
         mask_r  <= '0;
         cnt_r   <= '0;
         beat_r  <= '0;
         acc_r   <= SNP_NOHIT;
         tmo_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         op_r    <= op_s;
         addr_r  <= addr_s;
         id_r    <= id_s;
         ptr_r   <= ptr_s;
         mask_r  <= mask_s;
         cnt_r   <= cnt_s;
         beat_r  <= beat_s;
         acc_r   <= acc_s;
         tmo_r   <= tmo_s;
      end
   end

   // Outputs registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_valid   <= 1'b0;
         bus_msg     <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_snoop   <= SNP_NOHIT;
         rsp_timeout <= 1'b0;
         busy        <= 1'b0;
      end else begin
         busy      <= (state_s != ST_IDLE);
         bus_valid <= (state_s == ST_ADDR);
         rsp_valid <= (state_s == ST_RESP);
         if (state_s == ST_ADDR) begin
            bus_msg <= '{operation: op_s, address: addr_s, cache_id: CACHE_ID};
         end else begin
            bus_msg <= '0;
         end
         if (state_s == ST_RESP) begin
            rsp_id      <= id_s;
            rsp_snoop   <= acc_s;
            rsp_timeout <= tmo_s;
         end else begin
            rsp_id      <= '0;
            rsp_snoop   <= SNP_NOHIT;
            rsp_timeout <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_llc_bus_ctrl.sv
// Directed self-checking bench for llc_bus_ctrl: arbitration order, latency,
// snoop merging, timeout, beat counting and mid-transaction reset.
module tb_llc_bus_ctrl;
   import pkg_bus::*;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req_valid;
   logic [5:0]    req_op;
   logic [63:0]   req_addr;
   logic [1:0]    req_ready;
   logic          rsp_valid;
   logic [0:0]    rsp_id;
   snoop_result_e rsp_snoop;
   logic          rsp_timeout;
   logic          bus_valid;
   bus_msg_st     bus_msg;
   logic          bus_ack;
   logic [2:0]    snoop_valid;
   logic [5:0]    snoop_result;
   logic          beat_done;
   logic          busy;

   logic [2:0]    op_a   [2];
   logic [31:0]   addr_a [2];
   logic [1:0]    exp_g;
   logic [31:0]   exp_a;

   int vectors     = 0;
   int miscompares = 0;

   assign req_op   = {op_a[1], op_a[0]};
   assign req_addr = {addr_a[1], addr_a[0]};

   always #5 clk = ~clk;

   llc_bus_ctrl #(
      .NUM_REQ(2), .NUM_SNOOPERS(3), .DATA_BEATS(4), .SNOOP_TIMEOUT(16), .CACHE_ID(4'h0)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_snoop(rsp_snoop), .rsp_timeout(rsp_timeout),
      .bus_valid(bus_valid), .bus_msg(bus_msg), .bus_ack(bus_ack),
      .snoop_valid(snoop_valid), .snoop_result(snoop_result),
      .beat_done(beat_done), .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request in IDLE, check the grant pulse, and move into ADDR.
   task automatic issue(input logic [1:0] valid, input logic [2:0] op, input logic [31:0] addr,
                        input logic [1:0] exp_ready, input string tag);
      op_a[0] = op; op_a[1] = op; addr_a[0] = addr; addr_a[1] = addr;
      req_valid = valid;
      #1;
      check(tag, req_ready, exp_ready);
      tick();
      req_valid = 2'b00;
   endtask

   task automatic snoop_cycle(input logic [2:0] v, input logic [5:0] r);
      snoop_valid = v; snoop_result = r;
      tick();
      snoop_valid = 3'b000; snoop_result = 6'b0;
   endtask

   task automatic beats(input int n);
      beat_done = 1'b1;
      repeat (n) tick();
      beat_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 2'b00; bus_ack = 1'b0; snoop_valid = 3'b000;
      snoop_result = 6'b0; beat_done = 1'b0;
      op_a[0] = 3'b000; op_a[1] = 3'b000; addr_a[0] = 32'h0; addr_a[1] = 32'h0;
      tick(); tick();
      check("rst_busy", busy, 1'b0);
      check("rst_bus_valid", bus_valid, 1'b0);
      check("rst_bus_msg", bus_msg, 39'h0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_snoop", rsp_snoop, 2'b00);
      rst = 1'b0;
      tick();

      // Back-to-back INVALIDATEs from both requesters: alternate grants, 3-cycle latency.
      op_a[0] = 3'b011; op_a[1] = 3'b011;
      addr_a[0] = 32'hA000_0000; addr_a[1] = 32'hB000_0040;
      bus_ack = 1'b1; snoop_valid = 3'b111; snoop_result = 6'b00_01_00;
      req_valid = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_a = (k % 2 == 0) ? 32'hA000_0000 : 32'hB000_0040;
         check("t2_grant", req_ready, exp_g);
         tick();
         check("t2_addr", bus_msg.address, exp_a);
         tick();
         check("t2_no_rsp_snoop", rsp_valid, 1'b0);
         tick();
         check("t2_rsp_valid", rsp_valid, 1'b1);
         check("t2_rsp_id", rsp_id, exp_g[1]);
         check("t2_rsp_snoop", rsp_snoop, 2'b01);
         if (k == 3) req_valid = 2'b00;
         tick();
      end
      bus_ack = 1'b0; snoop_valid = 3'b000; snoop_result = 6'b0;
      check("t2_idle_busy", busy, 1'b0);

      // Single READ, bus_ack after two wait cycles, snoops {NOHIT,HIT,NOHIT}.
      issue(2'b01, 3'b001, 32'h0000_1040, 2'b01, "t1_ready");
      check("t1_bus_valid", bus_valid, 1'b1);
      check("t1_op", bus_msg.operation, 3'b001);
      check("t1_addr", bus_msg.address, 32'h0000_1040);
      check("t1_busy", busy, 1'b1);
      tick(); tick();
      check("t1_msg_hold", bus_msg, {3'b001, 32'h0000_1040, 4'h0});
      bus_ack = 1'b1; tick(); bus_ack = 1'b0;
      check("t1_addr_end", bus_valid, 1'b0);
      snoop_cycle(3'b111, 6'b00_01_00);
      beats(3);
      check("t1_no_rsp_3beats", rsp_valid, 1'b0);
      beats(1);
      check("t1_rsp_valid", rsp_valid, 1'b1);
      check("t1_rsp_id", rsp_id, 1'b0);
      check("t1_rsp_snoop", rsp_snoop, 2'b01);
      check("t1_rsp_timeout", rsp_timeout, 1'b0);
      tick();
      check("t1_rsp_pulse", rsp_valid, 1'b0);
      check("t1_idle", busy, 1'b0);

      // RWIM: HIT, HITM, then a repeat HIT from snooper 1 which must be ignored.
      issue(2'b01, 3'b100, 32'h0000_2080, 2'b01, "t3_ready_wrap");
      bus_ack = 1'b1; tick(); bus_ack = 1'b0;
      snoop_cycle(3'b001, 6'b00_00_01);
      snoop_cycle(3'b010, 6'b00_10_00);
      snoop_cycle(3'b010, 6'b00_01_00);
      snoop_cycle(3'b100, 6'b00_00_00);
      beats(4);
      check("t3_rsp_valid", rsp_valid, 1'b1);
      check("t3_rsp_snoop", rsp_snoop, 2'b10);
      tick();

      // INVALIDATE: snooper 1 HIT then a repeat HITM that must not upgrade the result.
      issue(2'b10, 3'b011, 32'h0000_30C0, 2'b10, "t3b_ready");
      bus_ack = 1'b1; tick(); bus_ack = 1'b0;
      snoop_cycle(3'b010, 6'b00_01_00);
      snoop_cycle(3'b111, 6'b00_10_00);
      check("t3b_rsp_valid", rsp_valid, 1'b1);
      check("t3b_rsp_id", rsp_id, 1'b1);
      check("t3b_rsp_snoop", rsp_snoop, 2'b01);
      tick();

      // WRITE with snooper 1 silent: timeout after 16 SNOOP cycles; beat_done outside DATA ignored.
      issue(2'b01, 3'b010, 32'h0000_4100, 2'b01, "t4_ready");
      bus_ack = 1'b1; tick(); bus_ack = 1'b0;
      beat_done = 1'b1;
      snoop_cycle(3'b101, 6'b00_00_01);
      repeat (18) tick();
      check("t4_not_early", rsp_valid, 1'b0);
      tick();
      beat_done = 1'b0;
      check("t4_rsp_valid", rsp_valid, 1'b1);
      check("t4_rsp_timeout", rsp_timeout, 1'b1);
      check("t4_rsp_snoop", rsp_snoop, 2'b01);
      tick();
      check("t4_timeout_pulse", rsp_timeout, 1'b0);

      // Reserved snoop code merges as NOHIT.
      issue(2'b10, 3'b011, 32'h0000_5000, 2'b10, "t6_ready");
      bus_ack = 1'b1; tick(); bus_ack = 1'b0;
      snoop_cycle(3'b111, 6'b00_00_11);
      check("t6_rsp_valid", rsp_valid, 1'b1);
      check("t6_rsp_snoop", rsp_snoop, 2'b00);
      check("t6_rsp_timeout", rsp_timeout, 1'b0);
      tick();

      // Reset in DATA after two beats drops the transaction and restarts the pointer.
      issue(2'b01, 3'b001, 32'h0000_6000, 2'b01, "t5_ready");
      bus_ack = 1'b1; tick(); bus_ack = 1'b0;
      snoop_cycle(3'b111, 6'b00_00_00);
      beats(2);
      check("t5_busy_before", busy, 1'b1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("t5_busy", busy, 1'b0);
      check("t5_bus_valid", bus_valid, 1'b0);
      check("t5_rsp_valid", rsp_valid, 1'b0);
      op_a[0] = 3'b011; op_a[1] = 3'b011;
      req_valid = 2'b11;
      #1;
      check("t5_ptr_restart", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      check("t5_no_rsp", rsp_valid, 1'b0);
      bus_ack = 1'b1; tick(); bus_ack = 1'b0;
      snoop_cycle(3'b111, 6'b00_00_01);
      check("t5_rsp_valid", rsp_valid, 1'b1);
      check("t5_rsp_id", rsp_id, 1'b0);
      check("t5_rsp_snoop", rsp_snoop, 2'b01);
      tick();
      check("t5_idle", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
